// File: rtl/loop_sampler_pkg.sv
// Shared types and constants for the ring-oscillator loop sampler.
// Used by loop_sampler and loop_sync.
package loop_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2,
        FULL = 2'd3
    } state_t;

    localparam int SYNC_STAGES   = 2;
    localparam int DISCARD_WIDTH = 16;

    function automatic logic [DISCARD_WIDTH-1:0] sat_inc(
        input logic [DISCARD_WIDTH-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/loop_sync.sv
// Multi-flop synchronizer for an asynchronous loop output.
// Reset value 0; only the last stage is exposed.
module loop_sync
    import loop_sampler_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic sync_d
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign sync_d = ff[STAGES-1];

endmodule

// File: rtl/loop_sampler.sv
// Seeds, free-runs and samples one entropy loop, packing bits into words.
// Optional von Neumann debias: define LOOP_SAMPLER_VON_NEUMANN_EN.
module loop_sampler
    import loop_sampler_pkg::*;
#(
    parameter int SEED_CYCLES = 4,
    parameter int RUN_CYCLES  = 64,
    parameter int WORD_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    output logic                     loop_ctrl,
    output logic                     loop_seed,
    input  logic                     loop_d,
    output logic [WORD_WIDTH-1:0]    data,
    output logic                     valid,
    input  logic                     ready,
    output logic [DISCARD_WIDTH-1:0] discards
);

    localparam int BW = $clog2(WORD_WIDTH + 1);
    localparam logic [15:0] SEED_LAST = 16'(SEED_CYCLES - 1);
    localparam logic [15:0] RUN_LAST  = 16'(RUN_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_WIDTH - 1);

    state_t state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic seed_q, seed_nx;
    logic [WORD_WIDTH-1:0] shreg;
    logic [WORD_WIDTH-1:0] data_q;
    logic [BW-1:0] bits;
    logic valid_q;
    logic sync_d;
    logic capture;
    logic load;
    logic pair_ok;
    logic acc_bit;
    logic accept;
    logic word_done;
    logic hs;
    logic out_free;

    loop_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (loop_d),
        .sync_d  (sync_d)
    );

`ifdef LOOP_SAMPLER_VON_NEUMANN_EN
    logic have_first;
    logic first_bit;
    logic [DISCARD_WIDTH-1:0] disc_q;

    // A pair is usable only when the second raw bit differs from the first.
    assign pair_ok = have_first && (first_bit != sync_d);
    assign acc_bit = first_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            have_first <= 1'b0;
            first_bit  <= 1'b0;
            disc_q     <= '0;
        end else if (capture) begin
            if (!have_first) begin
                have_first <= 1'b1;
                first_bit  <= sync_d;
            end else begin
                have_first <= 1'b0;
                if (first_bit == sync_d) begin
                    disc_q <= sat_inc(disc_q);
                end
            end
        end
    end

    assign discards = disc_q;
`else
    assign pair_ok  = 1'b1;
    assign acc_bit  = sync_d;
    assign discards = '0;
`endif

    assign hs        = valid_q && ready;
    assign out_free  = !valid_q || hs;
    assign accept    = capture && pair_ok;
    assign word_done = pair_ok && (bits == BIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            seed_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            seed_q <= seed_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        seed_nx  = seed_q;
        capture  = 1'b0;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = SEED;
                    cnt_nx   = '0;
                    seed_nx  = ~seed_q;
                end
            end
            SEED: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (cnt == SEED_LAST) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            RUN: begin
                if (cnt == RUN_LAST) begin
                    capture = 1'b1;
                    cnt_nx  = '0;
                    if (word_done) begin
                        state_nx = FULL;
                    end else if (enable) begin
                        state_nx = SEED;
                        seed_nx  = ~seed_q;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (!enable) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            FULL: begin
                if (out_free) begin
                    load   = 1'b1;
                    cnt_nx = '0;
                    if (enable) begin
                        state_nx = SEED;
                        seed_nx  = ~seed_q;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Reload in FULL wins over a handshake clear so words can go back-to-back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            bits    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= shreg;
            valid_q <= 1'b1;
            shreg   <= '0;
            bits    <= '0;
        end else begin
            if (hs) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                shreg <= {shreg[WORD_WIDTH-2:0], acc_bit};
                bits  <= bits + 1'b1;
            end
        end
    end

    assign loop_ctrl = (state != RUN);
    assign loop_seed = seed_q;
    assign data      = data_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_loop_sampler.sv
// Self-checking bench for loop_sampler (SEED 4, RUN 8, WORD 8).
// Word results go through a scoreboard queue checked at each handshake.
module tb_loop_sampler;
    import loop_sampler_pkg::*;

    localparam int SC = 4;
    localparam int RC = 8;
    localparam int WW = 8;
`ifdef LOOP_SAMPLER_VON_NEUMANN_EN
    localparam int R = 2;
`else
    localparam int R = 1;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic ready = 1'b0;
    logic loop_d = 1'b1;
    logic loop_ctrl;
    logic loop_seed;
    logic [WW-1:0] data;
    logic valid;
    logic [DISCARD_WIDTH-1:0] discards;

    loop_sampler #(
        .SEED_CYCLES (SC),
        .RUN_CYCLES  (RC),
        .WORD_WIDTH  (WW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .loop_ctrl (loop_ctrl),
        .loop_seed (loop_seed),
        .loop_d    (loop_d),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .discards  (discards)
    );

    always #5 clk = ~clk;

    int cmp = 0;
    int bad = 0;
    logic bitq[$];
    logic [WW-1:0] expq[$];
    int runs = 0;
    int seg = 0;
    logic prev_ctrl = 1'b1;
    int hi_log[$];
    int lo_log[$];
    logic seed_log[$];

    typedef struct {
        logic [WW-1:0] bits;
        logic [WW-1:0] exp;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Loop model: each RUN phase presents the next queued raw bit.
    always @(posedge clk) begin
        #1;
        if (loop_ctrl) begin
            if (!prev_ctrl) begin
                lo_log.push_back(seg);
                seg = 0;
            end
        end else if (prev_ctrl) begin
            hi_log.push_back(seg);
            seg = 0;
            runs++;
            seed_log.push_back(loop_seed);
            loop_d = (bitq.size() > 0) ? bitq.pop_front() : 1'b1;
        end
        seg++;
        prev_ctrl = loop_ctrl;
    end

    always @(negedge clk) begin
        if (reset_n && valid && ready) begin
            if (expq.size() == 0) begin
                cmp++;
                bad++;
                $display("FAIL word_unexpected: got %0h required none", data);
            end else begin
                chk("word", 64'(data), 64'(expq.pop_front()));
            end
        end
    end

    task automatic push_bit(input logic b);
`ifdef LOOP_SAMPLER_VON_NEUMANN_EN
        bitq.push_back(b);
        bitq.push_back(!b);
`else
        bitq.push_back(b);
`endif
    endtask

    task automatic push_word(input logic [WW-1:0] w);
        for (int i = WW - 1; i >= 0; i--) begin
            push_bit(w[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (expq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            cmp++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending required 0",
                     expq.size());
        end
    endtask

    task automatic wait_runs(input int target, input int budget);
        int n;
        n = 0;
        while (runs < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (runs < target) begin
            cmp++;
            bad++;
            $display("FAIL runs_timeout: got %0d required %0d", runs, target);
        end
    endtask

    task automatic clear_model();
        bitq.delete();
        expq.delete();
        hi_log.delete();
        lo_log.delete();
        seed_log.delete();
        runs = 0;
        loop_d = 1'b1;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        ready = 1'b0;
        #2;
        reset_n = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int n;
    int hold_ok;
    logic [WW-1:0] w1, w2, w3;

    initial begin
        vt[0] = '{bits: 8'hB2, exp: 8'hB2};
        vt[1] = '{bits: 8'h00, exp: 8'h00};
        vt[2] = '{bits: 8'h5A, exp: 8'h5A};
        vt[3] = '{bits: 8'h81, exp: 8'h81};
        vt[4] = '{bits: 8'h7E, exp: 8'h7E};

        // Reset values
        do_reset();
        chk("rst_loop_ctrl", 64'(loop_ctrl), 64'd1);
        chk("rst_loop_seed", 64'(loop_seed), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_discards", 64'(discards), 64'd0);

        // Timing, seed alternation, first word latency
        push_word(8'hFF);
        expq.push_back(8'hFF);
        enable = 1'b1;
        ready = 1'b1;
        release_reset();
        n = 0;
        while (!valid && n < 400) begin
            tick();
            n++;
        end
        chk("first_valid_cycle", 64'(n), 64'(2 + (SC + RC) * WW * R));
        wait_drain(50);
        enable = 1'b0;
        chk("run_len0", 64'(lo_log[0]), 64'(RC));
        chk("run_len1", 64'(lo_log[1]), 64'(RC));
        chk("seed_len1", 64'(hi_log[1]), 64'(SC));
        chk("seed_len2", 64'(hi_log[2]), 64'(SC));
        chk("seed_val0", 64'(seed_log[0]), 64'd1);
        chk("seed_val1", 64'(seed_log[1]), 64'd0);
        chk("seed_val2", 64'(seed_log[2]), 64'd1);
        chk("seed_val3", 64'(seed_log[3]), 64'd0);
        do_reset();

        // Table of packing vectors, back to back
        release_reset();
        for (int i = 0; i < 5; i++) begin
            push_word(vt[i].bits);
            expq.push_back(vt[i].exp);
        end
        enable = 1'b1;
        ready = 1'b1;
        wait_drain(5 * WW * R * (SC + RC) + 200);
        enable = 1'b0;
`ifndef LOOP_SAMPLER_VON_NEUMANN_EN
        chk("discards_tied", 64'(discards), 64'd0);
`endif
        do_reset();

        // Backpressure: three words, ready low until two are held
        w1 = 8'hC3;
        w2 = 8'h96;
        w3 = 8'h1E;
        release_reset();
        push_word(w1);
        push_word(w2);
        push_word(w3);
        expq.push_back(w1);
        expq.push_back(w2);
        expq.push_back(w3);
        enable = 1'b1;
        n = 0;
        while (!valid && n < 400) begin
            tick();
            n++;
        end
        chk("bp_first_valid", 64'(valid), 64'd1);
        chk("bp_first_data", 64'(data), 64'(w1));
        wait_runs(2 * WW * R, 400);
        repeat (20) @(negedge clk);
        hold_ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!loop_ctrl || !valid || data !== w1) hold_ok = 0;
        end
        chk("bp_hold", 64'(hold_ok), 64'd1);
        chk("bp_no_rounds", 64'(runs), 64'(2 * WW * R));
        tick();
        ready = 1'b1;
        tick();
        chk("bp_second_valid", 64'(valid), 64'd1);
        chk("bp_second_data", 64'(data), 64'(w2));
        wait_drain(WW * R * (SC + RC) + 100);
        enable = 1'b0;
        do_reset();

        // Enable drop mid-RUN after five accepted bits
        release_reset();
        push_bit(1'b1);
        push_bit(1'b0);
        push_bit(1'b1);
        push_bit(1'b1);
        push_bit(1'b0);
        bitq.push_back(1'b0);
        push_bit(1'b0);
        push_bit(1'b1);
        push_bit(1'b1);
        expq.push_back(8'hB3);
        enable = 1'b1;
        ready = 1'b1;
        wait_runs(5 * R + 1, 400);
        tick();
        tick();
        enable = 1'b0;
        tick();
        chk("drop_ctrl", 64'(loop_ctrl), 64'd1);
        repeat (6) @(negedge clk);
        chk("drop_idle_ctrl", 64'(loop_ctrl), 64'd1);
        chk("drop_no_rounds", 64'(runs), 64'(5 * R + 1));
        chk("drop_valid", 64'(valid), 64'd0);
        tick();
        enable = 1'b1;
        wait_drain(6 * R * (SC + RC) + 100);
        enable = 1'b0;
        do_reset();

`ifdef LOOP_SAMPLER_VON_NEUMANN_EN
        // Debias: pairs 00,11,01,10,10 then 01,10,01,01,10
        release_reset();
        bitq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        expq.push_back(8'h69);
        enable = 1'b1;
        ready = 1'b1;
        wait_runs(11, 400);
        chk("vn_discards", 64'(discards), 64'd2);
        chk("vn_not_valid", 64'(valid), 64'd0);
        wait_drain(20 * (SC + RC) + 100);
        chk("vn_discards_end", 64'(discards), 64'd2);
        enable = 1'b0;
        do_reset();
`endif

        // Asynchronous reset mid-RUN with four collected bits
        release_reset();
`ifdef LOOP_SAMPLER_VON_NEUMANN_EN
        bitq.push_back(1'b1);
        bitq.push_back(1'b1);
        n = 2;
`else
        n = 0;
`endif
        push_word(8'hF0);
        enable = 1'b1;
        ready = 1'b1;
        wait_runs(n + 4 * R + 1, 400);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ctrl", 64'(loop_ctrl), 64'd1);
        chk("arst_valid", 64'(valid), 64'd0);
        chk("arst_discards", 64'(discards), 64'd0);
        clear_model();
        push_word(8'h3C);
        expq.push_back(8'h3C);
        release_reset();
        wait_drain(WW * R * (SC + RC) + 100);
        enable = 1'b0;
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule

// File: doc/loop_sampler.md
Name: loop_sampler

Overview:
- Controller and digitizer for one ring-oscillator entropy loop; drives the loop's `ctrl`/`seed` inputs and samples its asynchronous `d` output.
- Each round seeds the loop, lets it free-run, then samples it through a synchronizer.
- Sampled bits are optionally debiased, packed into words and offered on a valid/ready interface.
- Sits between a loop instance and the entropy collector/mixer.

Parameters:
- SEED_CYCLES, 4: clock cycles `loop_ctrl` is held high per round (1..255).
- RUN_CYCLES, 64: clock cycles the loop free-runs per round (2..65535).
- WORD_WIDTH, 32: bits per output word (2..64).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run sampling rounds while high.
- loop_ctrl  out  1  to loop `ctrl`; 1 = force seed, 0 = free-run.
- loop_seed  out  1  to loop `seed`.
- loop_d  in  1  loop output; asynchronous to clk.
- data  out  WORD_WIDTH  collected word.
- valid  out  1  data holds an unconsumed word.
- ready  in  1  consumer accepts data when valid && ready at a rising clk edge.
- discards  out  16  saturating count of rejected raw pairs (debias only; else 0).

Behaviour:
- Reset values:
  - loop_ctrl=1, loop_seed=0, data=0, valid=0, discards=0.
  - Bit counter 0, shift register 0, synchronizer 0, state IDLE.
- Synchronizer: loop_d passes through 2 flops; only stage 2 (`sync_d`) is used.
- States IDLE, SEED, RUN, FULL:
  - IDLE:
    - loop_ctrl=1.
    - enable=1 -> SEED, cycle counter cleared.
  - SEED:
    - loop_ctrl=1 for exactly SEED_CYCLES cycles, then RUN.
    - loop_seed toggles at each SEED entry (first round after reset uses 1).
  - RUN:
    - loop_ctrl=0 for exactly RUN_CYCLES cycles.
    - In the last RUN cycle `sync_d` is captured as the raw bit.
    - Then: word complete -> FULL; else enable -> SEED; else IDLE.
  - FULL:
    - loop_ctrl=1.
    - When the output register is free (valid=0, or handshake this cycle), the shift register moves to data, valid=1, bit counter clears.
    - Then -> SEED if enable, else IDLE.
- enable low mid-round (SEED or RUN): return to IDLE next cycle with loop_ctrl=1. The current raw bit is discarded; collected bits and any pending debias first bit are retained.
- Round length is SEED_CYCLES+RUN_CYCLES cycles; one raw bit per round.
- Packing: accepted bit shifts into the LSB, so the first bit ends in the MSB. The word is complete when the counter reaches WORD_WIDTH.
- Output register:
  - valid stays high until the handshake; data is stable while valid=1.
  - The handshake clears valid in the next cycle unless FULL reloads it in the same cycle (back-to-back allowed).
  - If ready is high while valid=0, nothing happens.
- Simultaneous handshake and FULL transfer: the new word loads, valid stays 1.
- Asynchronous reset at any time returns to reset values; the loop is immediately forced to seed.

Optional Feature:
- Macro LOOP_SAMPLER_VON_NEUMANN_EN.
- Defined:
  - Raw bits are taken in pairs (first, second) from consecutive rounds.
  - 01 -> accept 0; 10 -> accept 1; 00/11 -> reject, and discards increments (saturating at 0xFFFF).
  - A word needs at least 2*WORD_WIDTH rounds.
- Undefined: every raw bit is accepted directly; discards is tied to 0.

Decomposition:
- Shared package `loop_sampler_pkg`:
  - state encoding constants (IDLE=0, SEED=1, RUN=2, FULL=3);
  - SYNC_STAGES=2;
  - DISCARD_WIDTH=16.
- Sub-module `loop_sync`: 2-flop synchronizer with async active-low reset and reset value 0; reusable for other loop variants.
- FSM, counters, debias and output register stay in loop_sampler.

Test Plan:
- Timing: SEED_CYCLES=4, RUN_CYCLES=8, WORD_WIDTH=8, macro off, enable=1, ready=1.
  - loop_d held 1 -> loop_ctrl high 4 / low 8 cycles repeating.
  - loop_seed alternates 1,0,1,...
  - First valid about 98 cycles after reset release (8 rounds + FULL), data=0xFF.
- Packing order: loop_d driven so the captured raw sequence is 1,0,1,1,0,0,1,0 -> data=0xB2.
- Backpressure: ready=0 for 3 words.
  - First word holds with valid=1, second waits in FULL with loop_ctrl=1 and no further rounds.
  - Raising ready -> second word appears the cycle after the first handshake; no bits lost.
- Enable drop:
  - Deassert enable mid-RUN after 5 accepted bits -> IDLE next cycle, loop_ctrl=1.
  - Re-enable -> word completes after 3 further rounds with the original 5 bits in the MSBs.
- Debias (macro on), raw pairs 00,11,01,10,10:
  - discards=2;
  - shift register gains bits 0,1,1;
  - with WORD_WIDTH=8, valid not asserted yet.
- Reset mid-RUN with 4 collected bits -> loop_ctrl=1, valid=0, discards=0 immediately (asynchronous); the next word contains only post-reset bits.
